multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_pkg.sv | 59 +++++
 rtl/multi_cycle_control_decode.sv | 62 ++++++
 rtl/multi_cycle_control.sv | 160 ++++++++++++++++
 tb/tb_multi_cycle_control.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_pkg.sv
// Shared encodings for the multi-cycle CPU controller: opcodes, FSM states,
// ALU operation codes, register-destination and PC-source selects.
package multi_cycle_pkg;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_WB_AL  = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM    = 4'd5,
        S_WB_LD  = 4'd6,
        S_EXE_BR = 4'd7,
        S_HALT   = 4'd8
    } state_e;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b011100;
    localparam logic [5:0] OP_SW    = 6'b100110;
    localparam logic [5:0] OP_LW    = 6'b100111;
    localparam logic [5:0] OP_BEQ   = 6'b110000;
    localparam logic [5:0] OP_BNE   = 6'b110001;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;

    localparam logic [1:0] RD_R31 = 2'b00;
    localparam logic [1:0] RD_RT  = 2'b01;
    localparam logic [1:0] RD_RD  = 2'b10;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    // Instruction classes steer the ID-state dispatch.
    localparam logic [2:0] CLS_NOP  = 3'd0;
    localparam logic [2:0] CLS_ALU  = 3'd1;
    localparam logic [2:0] CLS_LS   = 3'd2;
    localparam logic [2:0] CLS_BR   = 3'd3;
    localparam logic [2:0] CLS_JMP  = 3'd4;
    localparam logic [2:0] CLS_HALT = 3'd5;

endpackage

// File: rtl/multi_cycle_control_decode.sv
// Purely combinational opcode decode: ALU controls, extension mode,
// writeback register class and instruction class.
module control_decode
    import multi_cycle_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic [2:0] alu_op_o,
    output logic       ext_sel_o,
    output logic       alu_src_a_o,
    output logic       alu_src_b_o,
    output logic [1:0] reg_dst_o,
    output logic [2:0] op_class_o
);

    always_comb begin
        alu_op_o    = ALU_ADD;
        ext_sel_o   = 1'b0;
        alu_src_a_o = 1'b0;
        alu_src_b_o = 1'b0;
        reg_dst_o   = RD_R31;
        op_class_o  = CLS_NOP;
        unique case (opcode_i)
            OP_ADD:   begin op_class_o = CLS_ALU; reg_dst_o = RD_RD; end
            OP_SUB:   begin op_class_o = CLS_ALU; reg_dst_o = RD_RD; alu_op_o = ALU_SUB; end
            OP_AND:   begin op_class_o = CLS_ALU; reg_dst_o = RD_RD; alu_op_o = ALU_AND; end
            OP_OR:    begin op_class_o = CLS_ALU; reg_dst_o = RD_RD; alu_op_o = ALU_OR; end
            OP_SLL: begin
                op_class_o  = CLS_ALU;
                reg_dst_o   = RD_RD;
                alu_op_o    = ALU_SLL;
                alu_src_a_o = 1'b1;
            end
            OP_ADDIU: begin
                op_class_o = CLS_ALU; reg_dst_o = RD_RT;
                alu_src_b_o = 1'b1; ext_sel_o = 1'b1;
            end
            OP_ANDI: begin
                op_class_o = CLS_ALU; reg_dst_o = RD_RT;
                alu_src_b_o = 1'b1; alu_op_o = ALU_AND;
            end
            OP_ORI: begin
                op_class_o = CLS_ALU; reg_dst_o = RD_RT;
                alu_src_b_o = 1'b1; alu_op_o = ALU_OR;
            end
            OP_SLTI: begin
                op_class_o = CLS_ALU; reg_dst_o = RD_RT;
                alu_src_b_o = 1'b1; ext_sel_o = 1'b1; alu_op_o = ALU_SLT;
            end
            OP_LW, OP_SW: begin
                op_class_o = CLS_LS; reg_dst_o = RD_RT;
                alu_src_b_o = 1'b1; ext_sel_o = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                op_class_o = CLS_BR; ext_sel_o = 1'b1; alu_op_o = ALU_SUB;
            end
            OP_J, OP_JR, OP_JAL: op_class_o = CLS_JMP;
            OP_HALT:             op_class_o = CLS_HALT;
            default:             op_class_o = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control FSM with retired-instruction counter; all control
// outputs are combinational in the current state, opcode and zero flag.
module multi_cycle_control
    import multi_cycle_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  Opcode,
    input  logic        Zero,
    output logic        PCWre,
    output logic        IRWre,
    output logic        RegWre,
    output logic        mRD,
    output logic        mWR,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic        ExtSel,
    output logic        DBDataSrc,
    output logic        WrRegDSrc,
    output logic [1:0]  RegDst,
    output logic [1:0]  PCSrc,
    output logic [2:0]  ALUOp,
    output logic [3:0]  State,
    output logic [31:0] Retired
);

    state_e      state_q, state_d;
    logic [31:0] retired_q, retired_d;

    logic [2:0]  dec_alu_op;
    logic        dec_ext_sel;
    logic        dec_src_a;
    logic        dec_src_b;
    logic [1:0]  dec_reg_dst;
    logic [2:0]  dec_class;

    logic        pc_wre, ir_wre, reg_wre, mem_rd, mem_wr;
    logic        br_taken;

    control_decode u_decode (
        .opcode_i    (Opcode),
        .alu_op_o    (dec_alu_op),
        .ext_sel_o   (dec_ext_sel),
        .alu_src_a_o (dec_src_a),
        .alu_src_b_o (dec_src_b),
        .reg_dst_o   (dec_reg_dst),
        .op_class_o  (dec_class)
    );

    assign br_taken = ((Opcode == OP_BEQ) && Zero) || ((Opcode == OP_BNE) && !Zero);

    always_comb begin
        state_d   = state_q;
        pc_wre    = 1'b0;
        ir_wre    = 1'b0;
        reg_wre   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = ALU_ADD;
        DBDataSrc = 1'b0;
        WrRegDSrc = 1'b0;
        RegDst    = RD_R31;
        PCSrc     = PC_NEXT;
        unique case (state_q)
            S_IF: begin
                ir_wre  = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                unique case (dec_class)
                    CLS_ALU:  state_d = S_EXE_AL;
                    CLS_LS:   state_d = S_EXE_LS;
                    CLS_BR:   state_d = S_EXE_BR;
                    CLS_HALT: state_d = S_HALT;
                    default: begin
                        // Jumps and undefined opcodes complete here.
                        state_d = S_IF;
                        pc_wre  = 1'b1;
                        if (Opcode == OP_JR) begin
                            PCSrc = PC_RS;
                        end else if (Opcode == OP_J || Opcode == OP_JAL) begin
                            PCSrc = PC_JUMP;
                        end
                        if (Opcode == OP_JAL) begin
                            reg_wre = 1'b1;
                            RegDst  = RD_R31;
                        end
                    end
                endcase
            end
            S_EXE_AL, S_EXE_LS, S_EXE_BR: begin
                ALUOp   = dec_alu_op;
                ALUSrcA = dec_src_a;
                ALUSrcB = dec_src_b;
                ExtSel  = dec_ext_sel;
                if (state_q == S_EXE_AL) begin
                    state_d = S_WB_AL;
                end else if (state_q == S_EXE_LS) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_IF;
                    pc_wre  = 1'b1;
                    if (br_taken) PCSrc = PC_BRANCH;
                end
            end
            S_WB_AL: begin
                reg_wre   = 1'b1;
                WrRegDSrc = 1'b1;
                RegDst    = dec_reg_dst;
                pc_wre    = 1'b1;
                state_d   = S_IF;
            end
            S_MEM: begin
                if (Opcode == OP_LW) begin
                    mem_rd  = 1'b1;
                    state_d = S_WB_LD;
                end else begin
                    mem_wr  = 1'b1;
                    pc_wre  = 1'b1;
                    state_d = S_IF;
                end
            end
            S_WB_LD: begin
                reg_wre   = 1'b1;
                WrRegDSrc = 1'b1;
                DBDataSrc = 1'b1;
                RegDst    = RD_RT;
                pc_wre    = 1'b1;
                state_d   = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    assign retired_d = pc_wre ? retired_q + 32'd1 : retired_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IF;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Reset masks every write enable immediately, even the IF-state IRWre.
    assign PCWre   = pc_wre  & RST;
    assign IRWre   = ir_wre  & RST;
    assign RegWre  = reg_wre & RST;
    assign mRD     = mem_rd  & RST;
    assign mWR     = mem_wr  & RST;
    assign State   = state_q;
    assign Retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: per-cycle expected control words from a
// behavioural instruction model, checked by a decoupled monitor.
module tb_multi_cycle_control;
    import multi_cycle_pkg::*;

    localparam int W = 53;

    logic        CLK, RST, Zero;
    logic [5:0]  Opcode;
    logic        PCWre, IRWre, RegWre, mRD, mWR;
    logic        ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
    logic [1:0]  RegDst, PCSrc;
    logic [2:0]  ALUOp;
    logic [3:0]  State;
    logic [31:0] Retired;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [31:0] model_retired = 32'd0;

    multi_cycle_control dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Zero(Zero),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .mRD(mRD), .mWR(mWR),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
        .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .RegDst(RegDst),
        .PCSrc(PCSrc), .ALUOp(ALUOp), .State(State), .Retired(Retired)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] pack(
        input logic [3:0] st, input logic pcw, input logic irw, input logic rgw,
        input logic mrd, input logic mwr, input logic sa, input logic sb,
        input logic ext, input logic dbd, input logic wrd, input logic [1:0] rdst,
        input logic [1:0] pcs, input logic [2:0] aop, input logic [31:0] ret);
        return {st, pcw, irw, rgw, mrd, mwr, sa, sb, ext, dbd, wrd, rdst, pcs, aop, ret};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference model: instruction properties straight from the opcode table.
    function automatic bit in_set(input logic [5:0] op, input logic [5:0] s[]);
        foreach (s[i]) if (s[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] model_aluop(input logic [5:0] op);
        case (op)
            OP_SUB, OP_BEQ, OP_BNE: return 3'b001;
            OP_OR, OP_ORI:          return 3'b010;
            OP_AND, OP_ANDI:        return 3'b011;
            OP_SLTI:                return 3'b100;
            OP_SLL:                 return 3'b101;
            default:                return 3'b000;
        endcase
    endfunction

    task automatic issue(input logic [5:0] op, input logic z, input int halt_cycles);
        logic [3:0] seq[$];
        logic [5:0] rtype[] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL};
        logic [5:0] itype[] = '{OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI};
        logic [5:0] srcb[]  = '{OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW};
        logic [5:0] sext[]  = '{OP_ADDIU, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE};
        seq = {4'(S_IF), 4'(S_ID)};
        if (in_set(op, rtype) || in_set(op, itype)) seq.push_back(4'(S_EXE_AL));
        if (in_set(op, rtype) || in_set(op, itype)) seq.push_back(4'(S_WB_AL));
        if (op == OP_LW || op == OP_SW) seq.push_back(4'(S_EXE_LS));
        if (op == OP_LW || op == OP_SW) seq.push_back(4'(S_MEM));
        if (op == OP_LW) seq.push_back(4'(S_WB_LD));
        if (op == OP_BEQ || op == OP_BNE) seq.push_back(4'(S_EXE_BR));
        if (op == OP_HALT) for (int i = 0; i < halt_cycles; i++) seq.push_back(4'(S_HALT));
        foreach (seq[k]) begin
            logic [3:0] s;
            logic last, exe, pcw, rgw, wb;
            logic [1:0] rdst, pcs;
            s    = seq[k];
            last = (k == seq.size() - 1) && (s != 4'(S_HALT));
            exe  = (s == 4'(S_EXE_AL)) || (s == 4'(S_EXE_LS)) || (s == 4'(S_EXE_BR));
            wb   = (s == 4'(S_WB_AL)) || (s == 4'(S_WB_LD));
            pcw  = last;
            rgw  = wb || (s == 4'(S_ID) && op == OP_JAL);
            rdst = 2'b00;
            if (s == 4'(S_WB_AL)) rdst = in_set(op, rtype) ? 2'b10 : 2'b01;
            if (s == 4'(S_WB_LD)) rdst = 2'b01;
            pcs = 2'b00;
            if (last && op == OP_JR) pcs = 2'b10;
            if (last && (op == OP_J || op == OP_JAL)) pcs = 2'b11;
            if (last && ((op == OP_BEQ && z) || (op == OP_BNE && !z))) pcs = 2'b01;
            exp_q.push_back(pack(s, pcw, s == 4'(S_IF), rgw,
                                 s == 4'(S_MEM) && op == OP_LW, s == 4'(S_MEM) && op == OP_SW,
                                 exe && op == OP_SLL, exe && in_set(op, srcb),
                                 exe && in_set(op, sext), s == 4'(S_WB_LD), wb,
                                 rdst, pcs, exe ? model_aluop(op) : 3'b000, model_retired));
            if (last) model_retired++;
        end
        Opcode = op;
        Zero   = z;
        repeat (seq.size()) @(posedge CLK);
        #1;
    endtask

    // Monitor: every clock the DUT presents one control word.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            cyc++;
            check($sformatf("cycle_%0d", cyc),
                  64'(pack(State, PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB,
                           ExtSel, DBDataSrc, WrRegDSrc, RegDst, PCSrc, ALUOp, Retired)),
                  64'(e));
        end
    end

    logic [5:0] ops[16] = '{OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_OR, OP_ORI,
                            OP_SLL, OP_SLTI, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_J,
                            OP_JR, OP_JAL};

    initial begin
        RST = 1'b0; Opcode = OP_ADD; Zero = 1'b0;
        #2;
        check("reset_state", 64'(State), 64'(S_IF));
        check("reset_retired", 64'(Retired), 64'd0);
        check("reset_irwre", 64'(IRWre), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        model_retired = 32'd0;
        // IRWre was masked during reset; the FSM still sat in IF after release.
        // The edge just taken moved it to ID, so re-align with a reset pulse.
        RST = 1'b0; #1; RST = 1'b1; #1;

        issue(OP_ADD, 1'b0, 0);
        issue(OP_LW, 1'b0, 0);
        issue(OP_SW, 1'b1, 0);
        issue(OP_BEQ, 1'b1, 0);
        issue(OP_BNE, 1'b1, 0);
        issue(OP_BNE, 1'b0, 0);
        issue(OP_JAL, 1'b0, 0);
        issue(OP_JR, 1'b0, 0);
        issue(6'b101010, 1'b0, 0);

        // Reset in the middle of sw's MEM cycle.
        Opcode = OP_SW;
        exp_q.push_back(pack(S_IF, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, model_retired));
        exp_q.push_back(pack(S_ID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, model_retired));
        exp_q.push_back(pack(S_EXE_LS, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000, model_retired));
        repeat (3) @(posedge CLK);
        #1;
        check("sw_mem_state", 64'(State), 64'(S_MEM));
        check("sw_mem_mwr", 64'(mWR), 64'd1);
        RST = 1'b0; #1;
        check("midreset_mwr", 64'(mWR), 64'd0);
        check("midreset_state", 64'(State), 64'(S_IF));
        check("midreset_retired", 64'(Retired), 64'd0);
        RST = 1'b1;
        model_retired = 32'd0;

        for (int i = 0; i < 50; i++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 15)];
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom_range(0, 63));
                if (op == OP_HALT) op = 6'b101010;
            end
            issue(op, 1'($urandom_range(0, 1)), 0);
        end

        issue(OP_HALT, 1'b0, 100);
        RST = 1'b0; #1;
        check("halt_reset_state", 64'(State), 64'(S_IF));
        check("halt_reset_retired", 64'(Retired), 64'd0);
        check("halt_reset_pcwre", 64'(PCWre), 64'd0);
        RST = 1'b1;
        model_retired = 32'd0;

        issue(OP_SLL, 1'b0, 0);
        issue(OP_ORI, 1'b0, 0);
        issue(OP_J, 1'b0, 0);

        @(negedge CLK); #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
